// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and register file.
package wb_regfile_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam logic [DATA_W-1:0] LINK_OFFSET = 32'd8;

  // Write-back source selection, in priority order link > memory > ALU.
  typedef enum logic [1:0] {
    WB_SEL_ALU,
    WB_SEL_MEM,
    WB_SEL_LINK
  } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Three-way write-back value select: link address, load data or ALU result.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic              MemtoReg,
  input  logic              Link,
  input  logic [DATA_W-1:0] Aluout,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] wdata
);

  wb_sel_e sel;

  // Resolve the source; Link overrides MemtoReg.
  always_comb begin
    sel = WB_SEL_ALU;
    if (Link)
      sel = WB_SEL_LINK;
    else if (MemtoReg)
      sel = WB_SEL_MEM;
  end

  // Drive the selected value; the link address wraps modulo 2^DATA_W.
  always_comb begin
    wdata = Aluout;
    case (sel)
      WB_SEL_LINK: wdata = pc + LINK_OFFSET;
      WB_SEL_MEM:  wdata = rdata;
      default:     wdata = Aluout;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32 x 32 architectural register file with two
// bypassed decode read ports, a stored-value debug port and a commit counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              Link,
  input  logic [DATA_W-1:0] Aluout,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] pc,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs [REG_NUM];

  wb_mux u_wb_mux (
    .MemtoReg (MemtoReg),
    .Link     (Link),
    .Aluout   (Aluout),
    .rdata    (rdata),
    .pc       (pc),
    .wdata    (wdata)
  );

  // Writes to r0 are dropped here so they neither commit nor count.
  always_comb begin
    wen = RegWrite && (rd != '0);
  end

  // Commit the write-back value and count retired writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_NUM; i++)
        regs[i] <= '0;
      wb_count <= '0;
    end else if (wen) begin
      regs[rd] <= wdata;
      wb_count <= wb_count + CNT_W'(1);
    end
  end

  // Decode read ports; each port resolves its own bypass hit independently.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      if (BYPASS && wen && (raddr1 == rd))
        rdata1 = wdata;
      else
        rdata1 = regs[raddr1];
    end
    if (raddr2 != '0) begin
      if (BYPASS && wen && (raddr2 == rd))
        rdata2 = wdata;
      else
        rdata2 = regs[raddr2];
    end
  end

  // Debug port shows the stored value only.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0)
      dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a bypassed 32-bit-counter instance and a
// non-bypassed 3-bit-counter instance share the same stimulus.
module tb_wb_regfile;

  typedef struct {
    bit        rst, rw, m2r, lnk;
    bit [31:0] alu, ld, pc;
    bit [4:0]  rd, a1, a2, da;
  } stim_t;

  typedef struct {
    bit [31:0] wdata;
    bit        wen;
    bit [31:0] r1, r2, r1n, r2n, dbg, cnt;
    bit [2:0]  cnt0;
  } exp_t;

  logic        clk, reset, MemtoReg, RegWrite, Link;
  logic [31:0] Aluout, rdata, pc;
  logic [4:0]  rd, raddr1, raddr2, dbg_addr;
  logic [31:0] rdata1, rdata2, wdata, dbg_data, wb_count;
  logic        wen;
  logic [31:0] rdata1_n, rdata2_n, wdata_n, dbg_data_n;
  logic        wen_n;
  logic [2:0]  wb_count_n;

  int tests = 0;
  int failed = 0;

  exp_t q[$];
  bit [31:0] mregs [32];
  bit [31:0] mcnt;
  bit [2:0]  mcnt0;

  wb_regfile #(.BYPASS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Link(Link), .Aluout(Aluout), .rdata(rdata), .pc(pc), .rd(rd),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wdata(wdata), .wen(wen), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_count(wb_count)
  );

  wb_regfile #(.BYPASS(1'b0), .CNT_W(3)) dut_nb (
    .clk(clk), .reset(reset), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Link(Link), .Aluout(Aluout), .rdata(rdata), .pc(pc), .rd(rd),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .wdata(wdata_n), .wen(wen_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n),
    .wb_count(wb_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit [31:0] mread(input bit [4:0] a, input bit byp,
                                      input bit we, input bit [4:0] d,
                                      input bit [31:0] w);
    if (a == 0) return 32'd0;
    if (byp && we && a == d) return w;
    return mregs[a];
  endfunction

  // Drive one cycle of stimulus, queue its expected response, then advance
  // the reference model past the clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit [31:0] w;
    bit we;
    reset = s.rst; RegWrite = s.rw; MemtoReg = s.m2r; Link = s.lnk;
    Aluout = s.alu; rdata = s.ld; pc = s.pc; rd = s.rd;
    raddr1 = s.a1; raddr2 = s.a2; dbg_addr = s.da;
    if (s.rst) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      mcnt = 0;
      mcnt0 = 0;
    end
    w  = s.lnk ? s.pc + 32'd8 : (s.m2r ? s.ld : s.alu);
    we = s.rw && (s.rd != 0);
    e.wdata = w;
    e.wen   = we;
    e.r1    = mread(s.a1, 1'b1, we, s.rd, w);
    e.r2    = mread(s.a2, 1'b1, we, s.rd, w);
    e.r1n   = mread(s.a1, 1'b0, we, s.rd, w);
    e.r2n   = mread(s.a2, 1'b0, we, s.rd, w);
    e.dbg   = mread(s.da, 1'b0, we, s.rd, w);
    e.cnt   = mcnt;
    e.cnt0  = mcnt0;
    q.push_back(e);
    @(posedge clk);
    if (!s.rst && we) begin
      mregs[s.rd] = w;
      mcnt++;
      mcnt0++;
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so every mid-cycle sample is a response.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wdata",      wdata,      e.wdata);
      chk("wen",        {31'd0, wen}, {31'd0, e.wen});
      chk("rdata1",     rdata1,     e.r1);
      chk("rdata2",     rdata2,     e.r2);
      chk("dbg_data",   dbg_data,   e.dbg);
      chk("wb_count",   wb_count,   e.cnt);
      chk("nb_rdata1",  rdata1_n,   e.r1n);
      chk("nb_rdata2",  rdata2_n,   e.r2n);
      chk("nb_dbg",     dbg_data_n, e.dbg);
      chk("nb_wdata",   wdata_n,    e.wdata);
      chk("nb_wb_count", {29'd0, wb_count_n}, {29'd0, e.cnt0});
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rw: 1'b0, m2r: 1'b0, lnk: 1'b0, alu: 32'd0, ld: 32'd0,
          pc: 32'd0, rd: 5'd0, a1: 5'd0, a2: 5'd0, da: 5'd0};
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0; Link = 1'b0;
    Aluout = '0; rdata = '0; pc = '0; rd = '0;
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;
    @(posedge clk); #1;

    s = idle(); s.rst = 1'b1; step(s);
    for (int i = 0; i < 32; i++) begin
      s = idle(); s.a1 = 5'(i); s.a2 = 5'(31 - i); s.da = 5'(i); step(s);
    end

    // ALU write to r5, bypassed the same cycle, stored afterwards.
    s = idle(); s.rw = 1'b1; s.rd = 5'd5; s.alu = 32'h1234_5678; s.a1 = 5'd5; step(s);
    s = idle(); s.a1 = 5'd5; s.da = 5'd5; step(s);

    // Write to r0 is discarded.
    s = idle(); s.rw = 1'b1; s.rd = 5'd0; s.alu = 32'hFFFF_FFFF; s.a1 = 5'd0; step(s);
    s = idle(); s.a2 = 5'd0; s.da = 5'd0; step(s);

    // Link overrides MemtoReg and wraps pc + 8.
    s = idle(); s.rw = 1'b1; s.lnk = 1'b1; s.m2r = 1'b1; s.ld = 32'h1111_1111;
    s.pc = 32'hFFFF_FFFC; s.rd = 5'd31; s.a2 = 5'd31; step(s);
    s = idle(); s.da = 5'd31; s.a1 = 5'd31; step(s);

    // Load data to r7 read on both ports at once.
    s = idle(); s.rw = 1'b1; s.m2r = 1'b1; s.ld = 32'hDEAD_BEEF; s.rd = 5'd7;
    s.a1 = 5'd7; s.a2 = 5'd7; s.da = 5'd7; step(s);
    s = idle(); s.a1 = 5'd7; s.a2 = 5'd7; s.da = 5'd7; step(s);

    // Reset between edges clears state; the write presented during reset is lost.
    s = idle(); s.rw = 1'b1; s.rd = 5'd3; s.alu = 32'h0000_00A5; step(s);
    s = idle(); s.da = 5'd3; s.a1 = 5'd3; step(s);
    s = idle(); s.rst = 1'b1; s.rw = 1'b1; s.rd = 5'd3; s.alu = 32'h0000_0077;
    s.a1 = 5'd3; s.da = 5'd3; step(s);
    s = idle(); s.a1 = 5'd3; s.a2 = 5'd3; s.da = 5'd3; step(s);

    // Randomized traffic concentrated on a few registers to provoke bypass hits.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 63) == 0);
      s.rw  = ($urandom_range(0, 3) != 0);
      s.m2r = $urandom_range(0, 1) != 0;
      s.lnk = ($urandom_range(0, 3) == 0);
      s.alu = $urandom;
      s.ld  = $urandom;
      s.pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                          : $urandom;
      s.rd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      s.a1  = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 31));
      s.a2  = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 3));
      s.da  = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 31));
      step(s);
    end

    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32 x 32-bit register file. Serves the decode stage's two read ports with same-cycle write-through bypass, plus a debug read port and a retired-write counter for the test bench and board display.

## Interface
Parameters:
- BYPASS, 1: 1 = read ports return the value being written this cycle; 0 = return stored value.
- CNT_W, 32: width of the retired-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- MemtoReg  input  1  from MEM/WB; 1 selects rdata, 0 selects Aluout.
- RegWrite  input  1  from MEM/WB; write enable.
- Link  input  1  from MEM/WB; 1 selects pc + 8 (jal/jalr link), overrides MemtoReg.
- Aluout  input  32  ALU result from MEM/WB.
- rdata  input  32  load data from MEM/WB.
- pc  input  32  instruction PC from MEM/WB.
- rd  input  5  destination register from MEM/WB.
- raddr1, raddr2  input  5  decode-stage read addresses.
- rdata1, rdata2  output  32  read data, combinational.
- wdata  output  32  selected write-back value (to forwarding unit).
- wen  output  1  effective write enable: RegWrite && rd != 0.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  stored value of dbg_addr (no bypass).
- wb_count  output  CNT_W  number of committed writes since reset.

## Operation
- Write-back select, priority: Link -> pc + 8 (mod 2^32, carry discarded); else MemtoReg -> rdata; else Aluout.
- Commit: on rising clk with wen = 1, regs[rd] <= wdata. Writes with rd = 0 are discarded; regs[0] reads 0 always.
- Reads: rdataN = 0 if raddrN = 0; else if BYPASS && wen && raddrN == rd, wdata; else regs[raddrN]. Both ports may hit the same address or the write address simultaneously; each resolves independently.
- dbg_data = regs[dbg_addr] (stored value only, 0 for address 0).
- wb_count increments by 1 on each rising clk with wen = 1; wraps from 2^CNT_W - 1 to 0. RegWrite with rd = 0 does not count.
- Reset asserted: regs[1..31] = 0, wb_count = 0 immediately, independent of clk; writes presented during reset are lost. Deassertion mid-stream: first commit occurs on first rising clk with reset low.

## Timing
- Write latency: value visible in stored array (dbg_data, BYPASS = 0 reads) after the rising edge that commits it; visible on rdata1/2 in the same cycle when BYPASS = 1.
- Read ports and wdata/wen: purely combinational, no added cycle.
- Reset values: rdata1, rdata2, dbg_data = 0 (all regs 0, unless bypass active with inputs driven); wb_count = 0; wdata/wen follow inputs.
- No handshake; one commit per cycle maximum, no stall input.

## Structure
- Shared package: opcode-independent constants REG_NUM = 32, REG_AW = 5, DATA_W = 32, LINK_OFFSET = 8.
- One sub-module natural: wb_mux (three-way write-back select, combinational). Register array, bypass, counter live in wb_regfile.

## Test plan
- Reset then read all 32 addresses on rdata1, rdata2, dbg_data -> all 0; wb_count = 0.
- RegWrite=1, MemtoReg=0, rd=5, Aluout=0x1234_5678, raddr1=5 -> rdata1 = 0x1234_5678 same cycle (BYPASS=1), dbg_data at addr 5 = 0x1234_5678 after edge; wb_count = 1.
- RegWrite=1, rd=0, Aluout=0xFFFF_FFFF -> regs[0] reads 0, wen = 0, wb_count unchanged.
- Link=1, MemtoReg=1, pc=0xFFFF_FFFC, rd=31 -> wdata = 0x0000_0004 (wrap), regs[31] = 4.
- MemtoReg=1, rdata=0xDEAD_BEEF, rd=7, raddr1=raddr2=7 -> both ports 0xDEAD_BEEF same cycle; BYPASS=0 build -> old value until next cycle.
- Assert reset between clock edges after writing regs[3]=0xA5 -> rdata for addr 3 and wb_count drop to 0 before next edge; write presented during reset not committed.
